change_dispense_ctrl: RTL

CHANGE_DISPENSE_CTRL -- requirements
Module: change_dispense_ctrl

---
 rtl/coin_pkg.sv | 16 +
 rtl/change_dispense_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/coin_pkg.sv
// Shared definitions for the change dispenser: the controller state
// encoding and the coin weights, expressed in 5-cent units.
package coin_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    GAP      = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [7:0] NICKEL   = 8'd1;
  localparam logic [7:0] DIME     = 8'd2;
  localparam logic [7:0] TWO_DIME = 8'd4;

endpackage

// File: rtl/change_dispense_ctrl.sv
// Change dispense controller: keeps a shadow coin inventory, accepts a change
// request and pays it out greedily (two dimes, then dimes, then nickels) as
// one-cycle coin pulses, then reports completion and any unpaid remainder.
module change_dispense_ctrl
  import coin_pkg::*;
#(
  parameter int GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cfg_load,
  input  logic [7:0] cfg_nickels,
  input  logic [7:0] cfg_dimes,
  input  logic       req_valid,
  input  logic [7:0] req_amount,
  output logic       req_ready,
  output logic       load,
  output logic [7:0] nickels,
  output logic [7:0] dimes,
  output logic       nickel_out,
  output logic       dime_out,
  output logic       two_dime_out,
  output logic       done_valid,
  output logic       done_short,
  output logic [7:0] done_remaining,
  output logic [7:0] inv_nickels,
  output logic [7:0] inv_dimes
);

  // The gap counter counts down from GAP_CYCLES-1 so the FSM spends exactly
  // GAP_CYCLES cycles in GAP; with no gap a pulse returns straight to DISPENSE.
  localparam logic [3:0] GAP_LOAD   = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam state_t     POST_PULSE = (GAP_CYCLES == 0) ? DISPENSE : GAP;

  state_t     state_q;
  logic [7:0] remaining_q;
  logic [7:0] inv_nickels_q;
  logic [7:0] inv_dimes_q;
  logic [3:0] gap_cnt_q;
  logic       req_ready_q;
  logic       load_q;
  logic [7:0] nickels_q;
  logic [7:0] dimes_q;
  logic       nickel_out_q;
  logic       dime_out_q;
  logic       two_dime_out_q;
  logic       done_valid_q;
  logic       done_short_q;
  logic [7:0] done_remaining_q;

  // Controller FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      remaining_q      <= '0;
      inv_nickels_q    <= '0;
      inv_dimes_q      <= '0;
      gap_cnt_q        <= '0;
      req_ready_q      <= 1'b1;
      load_q           <= 1'b0;
      nickels_q        <= '0;
      dimes_q          <= '0;
      nickel_out_q     <= 1'b0;
      dime_out_q       <= 1'b0;
      two_dime_out_q   <= 1'b0;
      done_valid_q     <= 1'b0;
      done_short_q     <= 1'b0;
      done_remaining_q <= '0;
    end else begin
      load_q         <= 1'b0;
      nickel_out_q   <= 1'b0;
      dime_out_q     <= 1'b0;
      two_dime_out_q <= 1'b0;
      done_valid_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_load) begin
            inv_nickels_q <= cfg_nickels;
            inv_dimes_q   <= cfg_dimes;
            nickels_q     <= cfg_nickels;
            dimes_q       <= cfg_dimes;
            load_q        <= 1'b1;
          end else if (req_valid) begin
            remaining_q <= req_amount;
            req_ready_q <= 1'b0;
            state_q     <= DISPENSE;
          end
        end
        DISPENSE: begin
          // The inventory guards keep the counter's nickel fallback unused
          // and make every subtraction below underflow-free.
          if (remaining_q >= TWO_DIME && inv_dimes_q >= 8'd2) begin
            two_dime_out_q <= 1'b1;
            remaining_q    <= remaining_q - TWO_DIME;
            inv_dimes_q    <= inv_dimes_q - 8'd2;
            gap_cnt_q      <= GAP_LOAD;
            state_q        <= POST_PULSE;
          end else if (remaining_q >= DIME && inv_dimes_q >= 8'd1) begin
            dime_out_q  <= 1'b1;
            remaining_q <= remaining_q - DIME;
            inv_dimes_q <= inv_dimes_q - 8'd1;
            gap_cnt_q   <= GAP_LOAD;
            state_q     <= POST_PULSE;
          end else if (remaining_q >= NICKEL && inv_nickels_q >= 8'd1) begin
            nickel_out_q  <= 1'b1;
            remaining_q   <= remaining_q - NICKEL;
            inv_nickels_q <= inv_nickels_q - 8'd1;
            gap_cnt_q     <= GAP_LOAD;
            state_q       <= POST_PULSE;
          end else begin
            done_valid_q     <= 1'b1;
            done_short_q     <= (remaining_q != 8'd0);
            done_remaining_q <= remaining_q;
            state_q          <= DONE;
          end
        end
        GAP: begin
          if (gap_cnt_q == 4'd0) begin
            state_q <= DISPENSE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end
        DONE: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign load           = load_q;
  assign nickels        = nickels_q;
  assign dimes          = dimes_q;
  assign nickel_out     = nickel_out_q;
  assign dime_out       = dime_out_q;
  assign two_dime_out   = two_dime_out_q;
  assign done_valid     = done_valid_q;
  assign done_short     = done_short_q;
  assign done_remaining = done_remaining_q;
  assign inv_nickels    = inv_nickels_q;
  assign inv_dimes      = inv_dimes_q;

endmodule
